// File: rtl/program_loader.sv
// program_loader
//   Instruction store and boot loader sitting directly in front of the CPU
//   core. A framed byte stream is received over a valid/ready interface,
//   assembled into 16-bit instruction words and written to instruction RAM.
//   The core fetches from that RAM via a combinational pc-indexed read port.
//   The core is held in reset from frame start until the frame checksum
//   verifies.
//
//   Frame: START_BYTE, N, N words (high byte first), S
//     N = 0 means 2**PC_WIDTH words; S = 8-bit wrapping sum of all 2N data
//     bytes.
//
// Ports
//   clock        in   system clock, all state on posedge
//   isReset      in   synchronous active-high reset
//   rxByte       in   incoming byte
//   rxValid      in   rxByte valid
//   rxReady      out  loader can accept a byte this cycle
//   pc           in   core fetch address
//   instruction  out  ram[pc], combinational
//   cpuReset     out  core reset; high while no verified program is present
//   loadDone     out  last frame verified, core running
//   loadError    out  last frame failed its checksum
//   wordCount    out  words written in the current/last frame
//
// Handshake: a byte transfers on a posedge where rxValid && rxReady are both
// high; rxValid low means no transfer, whatever rxByte holds. rxReady is a
// decode of the registered state and drops only in the WRITE cycle.
//
// The FSM state is held in the named register `state` for hierarchical
// observation. PC_WIDTH must be at least 8 so the count byte fits the counter.

module program_loader #(
   parameter int              INSTRUCTION_WIDTH = 16,
   parameter int              PC_WIDTH          = 8,
   parameter logic [7:0]      START_BYTE        = 8'hA5
) (
   input  logic                         clock,
   input  logic                         isReset,
   input  logic [7:0]                   rxByte,
   input  logic                         rxValid,
   output logic                         rxReady,
   input  logic [PC_WIDTH-1:0]          pc,
   output logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic                         cpuReset,
   output logic                         loadDone,
   output logic                         loadError,
   output logic [PC_WIDTH:0]            wordCount
);

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      HIGH,
      LOW,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } state_t;

   // Count value used when the frame carries N = 0 (a full RAM image).
   localparam logic [PC_WIDTH:0] FULL_COUNT = {1'b1, {PC_WIDTH{1'b0}}};

   state_t                         state;
   logic [INSTRUCTION_WIDTH-1:0]   word;
   logic [7:0]                     checksum;
   logic [PC_WIDTH:0]              target;
   logic [PC_WIDTH-1:0]            addr;
   logic [INSTRUCTION_WIDTH-1:0]   ram [2**PC_WIDTH];

   logic accept;
   logic [PC_WIDTH:0] nextCount;

   assign rxReady   = (state != WRITE);
   assign accept    = rxValid && rxReady;
   assign nextCount = wordCount + 1'b1;

   // Control FSM
   always_ff @(posedge clock) begin
      if (isReset) begin
         state     <= IDLE;
         cpuReset  <= 1'b1;
         loadDone  <= 1'b0;
         loadError <= 1'b0;
         wordCount <= '0;
         checksum  <= '0;
         addr      <= '0;
         target    <= '0;
         word      <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               // Non-start bytes outside a frame are consumed and dropped.
               if (accept && rxByte == START_BYTE) begin
                  state     <= COUNT;
                  cpuReset  <= 1'b1;
                  loadDone  <= 1'b0;
                  loadError <= 1'b0;
                  wordCount <= '0;
                  checksum  <= '0;
               end
            end
            COUNT: begin
               if (accept) begin
                  if (rxByte == 8'h00)
                     target <= FULL_COUNT;
                  else
                     target <= {{(PC_WIDTH-7){1'b0}}, rxByte};
                  addr  <= '0;
                  state <= HIGH;
               end
            end
            HIGH: begin
               if (accept) begin
                  word[15:8] <= rxByte;
                  checksum   <= checksum + rxByte;
                  state      <= LOW;
               end
            end
            LOW: begin
               if (accept) begin
                  word[7:0] <= rxByte;
                  checksum  <= checksum + rxByte;
                  state     <= WRITE;
               end
            end
            WRITE: begin
               // RAM write happens in the array block below; address wraps.
               addr      <= addr + 1'b1;
               wordCount <= nextCount;
               state     <= (nextCount == target) ? CHECK : HIGH;
            end
            CHECK: begin
               if (accept) begin
                  if (rxByte == checksum) begin
                     state    <= DONE;
                     cpuReset <= 1'b0;
                     loadDone <= 1'b1;
                  end else begin
                     state     <= ERROR;
                     cpuReset  <= 1'b1;
                     loadError <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Instruction RAM: contents survive reset. The read is combinational, so a
   // read of the address being written in the WRITE cycle sees the old word.
   always_ff @(posedge clock) begin
      if (!isReset && state == WRITE)
         ram[addr] <= word;
   end

   assign instruction = ram[pc];

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames, a status scoreboard drained by a
// monitor on frame completion, and direct checks of RAM contents and timing.

module tb_program_loader;

   localparam int PW = 8;

   logic          clock;
   logic          isReset;
   logic [7:0]    rxByte;
   logic          rxValid;
   logic          rxReady;
   logic [PW-1:0] pc;
   logic [15:0]   instruction;
   logic          cpuReset;
   logic          loadDone;
   logic          loadError;
   logic [PW:0]   wordCount;

   int total = 0;
   int bad   = 0;

   // Expected frame result: {cpuReset, loadDone, loadError, wordCount}
   logic [11:0] exp_q[$];

   program_loader #(
      .INSTRUCTION_WIDTH(16),
      .PC_WIDTH(PW),
      .START_BYTE(8'hA5)
   ) dut (
      .clock(clock),
      .isReset(isReset),
      .rxByte(rxByte),
      .rxValid(rxValid),
      .rxReady(rxReady),
      .pc(pc),
      .instruction(instruction),
      .cpuReset(cpuReset),
      .loadDone(loadDone),
      .loadError(loadError),
      .wordCount(wordCount)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] pack(input logic cr, input logic ld, input logic le,
                                        input logic [8:0] wc);
      return {cr, ld, le, wc};
   endfunction

   // Presents a byte and returns #1 after the edge that accepted it.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      rxByte  = b;
      rxValid = 1'b1;
      waited  = 0;
      while (!rxReady && waited < 8) begin
         @(posedge clock);
         #1;
         waited++;
      end
      if (!rxReady) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: rxReady stuck at %b expected 1 at %0t", rxReady, $time);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      rxValid = 1'b0;
   endtask

   task automatic read_check(input logic [PW-1:0] a, input logic [15:0] exp);
      pc = a;
      @(negedge clock);
      check($sformatf("ram[%0d]", a), {16'h0, instruction}, {16'h0, exp});
      @(posedge clock);
      #1;
   endtask

   // Bounded wait for the monitor to consume all expected frame results.
   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d frame results pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clock);
      #1;
   endtask

   // ---------------- monitor ----------------
   logic prev_fin = 1'b0;
   always @(negedge clock) begin
      logic fin;
      logic [11:0] e;
      fin = loadDone | loadError;
      if (fin === 1'b1 && prev_fin === 1'b0) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion: status %h, expected none",
                     {cpuReset, loadDone, loadError, wordCount});
         end else begin
            e = exp_q.pop_front();
            check("frame_status", {20'h0, cpuReset, loadDone, loadError, wordCount}, {20'h0, e});
         end
      end
      prev_fin = fin;
   end

   // ---------------- stimulus ----------------
   initial begin
      isReset = 1'b1;
      rxValid = 1'b0;
      rxByte  = 8'h00;
      pc      = '0;
      repeat (2) @(posedge clock);
      #1;
      isReset = 1'b0;

      // reset state
      check("rst_rxReady", rxReady, 1);
      check("rst_cpuReset", cpuReset, 1);
      check("rst_loadDone", loadDone, 0);
      check("rst_loadError", loadError, 0);
      check("rst_wordCount", wordCount, 0);

      // 1: basic two-word frame, checksum 12+34+56+78 = 114 -> 14
      exp_q.push_back(pack(0, 1, 0, 9'd2));
      send_byte(8'hA5); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      check("t1_cpuReset_before_sum", cpuReset, 1);
      send_byte(8'h14);
      idle();
      check("t1_cpuReset_falls", cpuReset, 0);
      pc = 8'd0;
      #1;
      check("t1_fetch_pc0", instruction, 16'h1234);
      wait_drain();
      read_check(8'd0, 16'h1234);
      read_check(8'd1, 16'h5678);

      // 2: bad checksum, then recovery frame (0F+F0 = FF)
      exp_q.push_back(pack(1, 0, 1, 9'd2));
      send_byte(8'hA5); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      send_byte(8'h15);
      idle();
      wait_drain();
      exp_q.push_back(pack(0, 1, 0, 9'd1));
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h0F); send_byte(8'hF0);
      send_byte(8'hFF);
      idle();
      wait_drain();
      read_check(8'd0, 16'h0FF0);

      // 3: junk bytes dropped, rxValid held high, WRITE bubble (AB+CD = 78)
      send_byte(8'h00); send_byte(8'hFF);
      check("t3_junk_loadDone", loadDone, 1);
      check("t3_junk_wordCount", wordCount, 1);
      exp_q.push_back(pack(0, 1, 0, 9'd1));
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAB);
      send_byte(8'hCD);
      check("t3_ready_low", rxReady, 0);
      rxByte = 8'h78;
      @(posedge clock);
      #1;
      check("t3_ready_back", rxReady, 1);
      send_byte(8'h78);
      idle();
      wait_drain();
      read_check(8'd0, 16'hABCD);

      // 4: N=0 -> 256 words of 0101, checksum 512*01 mod 256 = 00
      exp_q.push_back(pack(0, 1, 0, 9'd256));
      send_byte(8'hA5); send_byte(8'h00);
      for (int i = 0; i < 512; i++) send_byte(8'h01);
      send_byte(8'h00);
      idle();
      wait_drain();
      read_check(8'd0, 16'h0101);
      read_check(8'd1, 16'h0101);
      read_check(8'd128, 16'h0101);
      read_check(8'd255, 16'h0101);

      // 5: reset after the 3rd data byte, then a fresh frame (CA+FE = C8)
      send_byte(8'hA5); send_byte(8'h02);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
      idle();
      isReset = 1'b1;
      @(posedge clock);
      #1;
      isReset = 1'b0;
      check("t5_cpuReset", cpuReset, 1);
      check("t5_loadDone", loadDone, 0);
      check("t5_wordCount", wordCount, 0);
      check("t5_rxReady", rxReady, 1);
      read_check(8'd0, 16'hDEAD);
      read_check(8'd1, 16'h0101);
      exp_q.push_back(pack(0, 1, 0, 9'd1));
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hCA); send_byte(8'hFE);
      send_byte(8'hC8);
      idle();
      wait_drain();
      read_check(8'd0, 16'hCAFE);

      // 6: start byte in DONE restarts; overwrite from address 0 (11+22 = 33)
      send_byte(8'hA5);
      idle();
      check("t6_cpuReset", cpuReset, 1);
      check("t6_loadDone", loadDone, 0);
      check("t6_wordCount", wordCount, 0);
      exp_q.push_back(pack(0, 1, 0, 9'd1));
      send_byte(8'h01); send_byte(8'h11);
      pc = 8'd0;
      send_byte(8'h22);
      idle();
      check("t6_read_old_in_write", instruction, 16'hCAFE);
      @(posedge clock);
      #1;
      check("t6_read_new", instruction, 16'h1122);
      send_byte(8'h33);
      idle();
      wait_drain();
      read_check(8'd0, 16'h1122);
      read_check(8'd1, 16'h0101);

      check("leftover_expected", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
